window_scan_ctrl: RTL and testbench
===================================

// Module: window_scan_ctrl
// PURPOSE
//  Frame sequencer for the 3x3 window line memory of the convolution datapath.
//  After a start pulse it issues one window-read enable per output pixel, raster order, over the zero-padded frame.
//  It generates the matching output write enable, delayed by the filter pipeline latency, plus read/write addresses.
//  It signals busy/done to the top-level control. Sits between top-level control and the window memory / filter pipeline.
// PARAMETERS
//  IMG_W   256  output image width in pixels (padded row pitch = IMG_W+2)
//  IMG_H   32   output image height in rows
//  LAT     2    cycles from mem_rd to the filtered pixel being valid at the memory write port (>=1)
//  AW      15   address/count width; must hold (IMG_H+1)*(IMG_W+2)
// PORTS
//  clk      in   1    system clock, all logic on rising edge
//  rst      in   1    synchronous reset, active-high
//  start    in   1    one-cycle request to process a frame; honoured only in IDLE
//  hold     in   1    downstream stall; freezes read issue (pipeline keeps draining)
//  mem_rd   out  1    window-read enable to line memory
//  rd_addr  out  AW   window top-left index = row*(IMG_W+2)+col, valid while mem_rd=1
//  mem_wr   out  1    output-pixel write enable to line memory
//  wr_addr  out  AW   output pixel index 0..IMG_W*IMG_H-1, valid while mem_wr=1
//  col      out  8    current output column
//  row      out  6    current output row
//  busy     out  1    high from cycle after accepted start until done
//  done     out  1    one-cycle pulse, frame complete
// BEHAVIOUR
//  Reset: state=IDLE; mem_rd, mem_wr, busy, done=0; rd_addr, wr_addr, col, row=0; delay line cleared.
//  rst mid-frame aborts immediately; no further mem_wr; the next start restarts at address 0.
//  FSM:
//   IDLE  -> READ when start=1. Clear col, row, rd_addr, wr_addr.
//   READ  -> mem_rd=!hold (combinational from state/hold); counters advance only when mem_rd=1.
//            col wraps IMG_W-1 -> 0 with row+1; rd_addr += 1 within a row, += 3 at row wrap.
//            The read with row=IMG_H-1, col=IMG_W-1 is the last; the next state is DRAIN.
//   DRAIN -> mem_rd=0. Go to DONE when the delay line is empty and mem_wr=0.
//   DONE  -> done=1 for exactly one cycle, busy=0 -> IDLE.
//  busy=1 in READ and DRAIN only. start outside IDLE (including DONE) is ignored and has no side effects.
//  mem_wr = mem_rd delayed exactly LAT cycles (LAT-bit shift register, shifts every cycle regardless of hold).
//   hold bubbles therefore reappear as mem_wr gaps.
//  wr_addr increments after each mem_wr=1 cycle; it ends at IMG_W*IMG_H.
//  Exactly IMG_W*IMG_H mem_rd and mem_wr pulses per frame.
//  Address arithmetic unsigned, no overflow by construction of AW.
//  hold in IDLE/DRAIN/DONE has no effect.
// STRUCTURE
//  scan_pkg: state encodings (IDLE/READ/DRAIN/DONE), PAD_W=IMG_W+2 helper, default geometry constants.
//  Sub-module valid_delay #(LAT): shift-register delay of a 1-bit valid.
//   Provides an empty flag (OR of stages) used by DRAIN.
//  Remainder in one file: FSM, col/row/rd_addr counters, wr_addr counter.
// TESTING (defaults unless noted; start sampled high at cycle 0)
//  1. Reset, then start -> mem_rd high in cycles 1..8192, mem_wr high in cycles 3..8194, done pulse at cycle 8195, busy 1..8194.
//  2. Address trace -> rd_addr 0..255, 258..513, ..., last 8253; wr_addr 0..8191 contiguous.
//  3. hold=1 for 10 cycles mid-row 5 -> 10-cycle gap in mem_rd and the same gap LAT later in mem_wr.
//     col/row frozen during the gap; still 8192 pulses; done at cycle 8205.
//  4. start pulsed at cycles 50 and 8195 (DONE) -> both ignored; start at 8196 accepted, new frame from rd_addr 0.
//  5. rst at cycle 100 -> cycle 101: all outputs 0, no mem_wr afterwards; a restart reproduces scenario 1 timing.
//  6. IMG_W=4, IMG_H=2, LAT=1 -> rd_addr 0,1,2,3,6,7,8,9; mem_wr one cycle behind; done two cycles after last mem_rd.

Source files
------------

// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared state encodings and geometry defaults for the window scan sequencer
package scan_pkg;

    localparam int DEF_IMG_W = 256;
    localparam int DEF_IMG_H = 32;
    localparam int DEF_LAT   = 2;
    localparam int DEF_AW    = 15;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } scan_state_t;

    // Row pitch of the zero-padded frame held in the window memory.
    function automatic int pad_w(input int img_w);
        return img_w + 2;
    endfunction

endpackage

// File: rtl/valid_delay.sv
// rtl/valid_delay.sv - fixed-latency shift-register delay of a 1-bit valid with pending flag
module valid_delay #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic empty
);

    logic [LAT-1:0] sr;
    logic [LAT-1:0] nxt;

    generate
        if (LAT == 1) begin : g_one
            assign nxt = din;
        end else begin : g_multi
            assign nxt = {sr[LAT-2:0], din};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= nxt;
        end
    end

    assign dout  = sr[LAT-1];
    // Nothing will be in flight after this edge: the stage now presenting is the last one.
    assign empty = ~|nxt;

endmodule

// File: rtl/window_scan_ctrl.sv
// rtl/window_scan_ctrl.sv - raster frame sequencer issuing window reads and delayed pixel writes
module window_scan_ctrl
    import scan_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int LAT   = DEF_LAT,
    parameter int AW    = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          hold,
    output logic          mem_rd,
    output logic [AW-1:0] rd_addr,
    output logic          mem_wr,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    col,
    output logic [5:0]    row,
    output logic          busy,
    output logic          done
);

    localparam logic [7:0]    COL_LAST = 8'(IMG_W - 1);
    localparam logic [5:0]    ROW_LAST = 6'(IMG_H - 1);
    // Skipping the two pad columns at the end of a row plus the normal step of one.
    localparam logic [AW-1:0] ROW_STEP = AW'(pad_w(IMG_W) - IMG_W + 1);

    scan_state_t state;
    logic        last_rd;
    logic        dl_empty;

    assign mem_rd  = (state == S_READ) && !hold;
    assign last_rd = (row == ROW_LAST) && (col == COL_LAST);
    assign busy    = (state == S_READ) || (state == S_DRAIN);
    assign done    = (state == S_DONE);

    valid_delay #(.LAT(LAT)) u_delay (
        .clk   (clk),
        .rst   (rst),
        .din   (mem_rd),
        .dout  (mem_wr),
        .empty (dl_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            col     <= '0;
            row     <= '0;
            rd_addr <= '0;
            wr_addr <= '0;
        end else begin
            if (mem_wr) begin
                wr_addr <= wr_addr + AW'(1);
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_READ;
                        col     <= '0;
                        row     <= '0;
                        rd_addr <= '0;
                        wr_addr <= '0;
                    end
                end
                S_READ: begin
                    if (mem_rd) begin
                        if (col == COL_LAST) begin
                            col     <= '0;
                            row     <= row + 6'd1;
                            rd_addr <= rd_addr + ROW_STEP;
                        end else begin
                            col     <= col + 8'd1;
                            rd_addr <= rd_addr + AW'(1);
                        end
                        if (last_rd) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (dl_empty) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// tb/tb_window_scan_ctrl.sv - scoreboard bench for window_scan_ctrl, default and tiny geometries
module tb_window_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, hold, start_b, hold_b;
    logic        mem_rd, mem_wr, busy, done;
    logic [14:0] rd_addr, wr_addr;
    logic [7:0]  col;
    logic [5:0]  row;
    logic        mem_rd_b, mem_wr_b, busy_b, done_b;
    logic [14:0] rd_addr_b, wr_addr_b;
    logic [7:0]  col_b;
    logic [5:0]  row_b;

    window_scan_ctrl dut_a (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .mem_rd(mem_rd), .rd_addr(rd_addr), .mem_wr(mem_wr), .wr_addr(wr_addr),
        .col(col), .row(row), .busy(busy), .done(done)
    );

    window_scan_ctrl #(.IMG_W(4), .IMG_H(2), .LAT(1), .AW(15)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .hold(hold_b),
        .mem_rd(mem_rd_b), .rd_addr(rd_addr_b), .mem_wr(mem_wr_b), .wr_addr(wr_addr_b),
        .col(col_b), .row(row_b), .busy(busy_b), .done(done_b)
    );

    typedef struct {
        int cyc;
        int addr;
        int col;
        int row;
    } ev_t;

    ev_t q_rd[$], q_wr[$], q_rd_b[$], q_wr_b[$];
    int  q_done[$], q_done_b[$];
    int  checks = 0, failures = 0;
    int  ncyc = 0;
    int  base_a = 0, base_b = 0;

    always @(posedge clk) ncyc <= ncyc + 1;

    task automatic check(input string name, input bit ok, input string act, input string exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %s, expected %s", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon_a
        int  c;
        ev_t e;
        c = ncyc - base_a;
        if (mem_rd) begin
            if (q_rd.size() == 0) check("a_rd_unexpected", 1'b0, $sformatf("mem_rd cyc=%0d", c), "no mem_rd");
            else begin
                e = q_rd.pop_front();
                check("a_rd", c == e.cyc && int'(rd_addr) == e.addr && int'(col) == e.col && int'(row) == e.row && busy,
                      $sformatf("cyc=%0d addr=%0d col=%0d row=%0d busy=%0b", c, rd_addr, col, row, busy),
                      $sformatf("cyc=%0d addr=%0d col=%0d row=%0d busy=1", e.cyc, e.addr, e.col, e.row));
            end
        end
        if (mem_wr) begin
            if (q_wr.size() == 0) check("a_wr_unexpected", 1'b0, $sformatf("mem_wr cyc=%0d", c), "no mem_wr");
            else begin
                e = q_wr.pop_front();
                check("a_wr", c == e.cyc && int'(wr_addr) == e.addr && busy,
                      $sformatf("cyc=%0d addr=%0d busy=%0b", c, wr_addr, busy),
                      $sformatf("cyc=%0d addr=%0d busy=1", e.cyc, e.addr));
            end
        end
        if (done) begin
            if (q_done.size() == 0) check("a_done_unexpected", 1'b0, $sformatf("done cyc=%0d", c), "no done");
            else begin
                e.cyc = q_done.pop_front();
                check("a_done", c == e.cyc && !busy,
                      $sformatf("cyc=%0d busy=%0b", c, busy), $sformatf("cyc=%0d busy=0", e.cyc));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        int  c;
        ev_t e;
        c = ncyc - base_b;
        if (mem_rd_b) begin
            if (q_rd_b.size() == 0) check("b_rd_unexpected", 1'b0, $sformatf("mem_rd cyc=%0d", c), "no mem_rd");
            else begin
                e = q_rd_b.pop_front();
                check("b_rd", c == e.cyc && int'(rd_addr_b) == e.addr && int'(col_b) == e.col && int'(row_b) == e.row,
                      $sformatf("cyc=%0d addr=%0d col=%0d row=%0d", c, rd_addr_b, col_b, row_b),
                      $sformatf("cyc=%0d addr=%0d col=%0d row=%0d", e.cyc, e.addr, e.col, e.row));
            end
        end
        if (mem_wr_b) begin
            if (q_wr_b.size() == 0) check("b_wr_unexpected", 1'b0, $sformatf("mem_wr cyc=%0d", c), "no mem_wr");
            else begin
                e = q_wr_b.pop_front();
                check("b_wr", c == e.cyc && int'(wr_addr_b) == e.addr,
                      $sformatf("cyc=%0d addr=%0d", c, wr_addr_b), $sformatf("cyc=%0d addr=%0d", e.cyc, e.addr));
            end
        end
        if (done_b) begin
            if (q_done_b.size() == 0) check("b_done_unexpected", 1'b0, $sformatf("done cyc=%0d", c), "no done");
            else begin
                e.cyc = q_done_b.pop_front();
                check("b_done", c == e.cyc && !busy_b,
                      $sformatf("cyc=%0d busy=%0b", c, busy_b), $sformatf("cyc=%0d busy=0", e.cyc));
            end
        end
    end

    // Default frame: read i at cycle off+1+i (pushed back by hl once read hi is reached), write LAT=2 later.
    task automatic exp_frame(input int off, input int hi, input int hl, input int lim);
        for (int i = 0; i < 8192; i++) begin
            ev_t e;
            int  rc;
            rc     = off + 1 + i + ((hl > 0 && i >= hi) ? hl : 0);
            e.cyc  = rc;
            e.addr = (i / 256) * 258 + (i % 256);
            e.col  = i % 256;
            e.row  = i / 256;
            if (rc <= lim) q_rd.push_back(e);
            e.cyc  = rc + 2;
            e.addr = i;
            if (rc + 2 <= lim) q_wr.push_back(e);
        end
        if (off + 8195 + hl <= lim) q_done.push_back(off + 8195 + hl);
    endtask

    task automatic run_a(input int ncycles, input int hi, input int hl,
                         input int s1, input int s2, input int s3, input int rst_at);
        @(posedge clk); #1;
        base_a = ncyc;
        start  = 1'b1;
        for (int c = 1; c <= ncycles; c++) begin
            @(posedge clk); #1;
            start = (c == s1) || (c == s2) || (c == s3);
            hold  = (hl > 0) && (c >= hi + 1) && (c < hi + 1 + hl);
            rst   = (c == rst_at);
            #1;
            if (hl > 0 && c == hi + 6)
                check("hold_freeze", int'(col) == hi % 256 && int'(row) == hi / 256 && !mem_rd,
                      $sformatf("col=%0d row=%0d mem_rd=%0b", col, row, mem_rd),
                      $sformatf("col=%0d row=%0d mem_rd=0", hi % 256, hi / 256));
            if (rst_at > 0 && c == rst_at + 1)
                check("rst_abort", {mem_rd, mem_wr, busy, done} == 4'b0 && rd_addr == 15'd0 && wr_addr == 15'd0
                      && col == 8'd0 && row == 6'd0,
                      $sformatf("rd=%0b wr=%0b busy=%0b done=%0b ra=%0d wa=%0d col=%0d row=%0d",
                                mem_rd, mem_wr, busy, done, rd_addr, wr_addr, col, row), "all zero");
        end
        start = 1'b0;
        hold  = 1'b0;
        rst   = 1'b0;
        check("a_rd_left", q_rd.size() == 0, $sformatf("%0d pending", q_rd.size()), "0 pending");
        check("a_wr_left", q_wr.size() == 0, $sformatf("%0d pending", q_wr.size()), "0 pending");
        check("a_done_left", q_done.size() == 0, $sformatf("%0d pending", q_done.size()), "0 pending");
    endtask

    initial begin
        int rd_tbl[8];
        rd_tbl = '{0, 1, 2, 3, 6, 7, 8, 9};
        rst = 1'b1; start = 1'b0; hold = 1'b0; start_b = 1'b0; hold_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", {mem_rd, mem_wr, busy, done} == 4'b0 && rd_addr == 15'd0 && wr_addr == 15'd0
              && col == 8'd0 && row == 6'd0,
              $sformatf("rd=%0b wr=%0b busy=%0b done=%0b ra=%0d wa=%0d", mem_rd, mem_wr, busy, done, rd_addr, wr_addr),
              "all zero");
        check("reset_b", {mem_rd_b, mem_wr_b, busy_b, done_b} == 4'b0 && rd_addr_b == 15'd0 && wr_addr_b == 15'd0,
              $sformatf("rd=%0b wr=%0b busy=%0b done=%0b", mem_rd_b, mem_wr_b, busy_b, done_b), "all zero");
        rst = 1'b0;

        // Plain frame: timing and full address trace.
        exp_frame(0, 0, 0, 1 << 30);
        run_a(8198, 0, 0, -1, -1, -1, -1);

        // Ten-cycle hold starting at row 5, col 100.
        exp_frame(0, 1380, 10, 1 << 30);
        run_a(8208, 1380, 10, -1, -1, -1, -1);

        // Starts during READ and DONE ignored; the one in IDLE begins a second frame.
        exp_frame(0, 0, 0, 1 << 30);
        exp_frame(8196, 0, 0, 1 << 30);
        run_a(16394, 0, 0, 50, 8195, 8196, -1);

        // Abort at cycle 100, then a clean restart.
        exp_frame(0, 0, 0, 100);
        run_a(200, 0, 0, -1, -1, -1, 100);
        exp_frame(0, 0, 0, 1 << 30);
        run_a(8198, 0, 0, -1, -1, -1, -1);

        // Tiny geometry, LAT=1.
        for (int i = 0; i < 8; i++) begin
            ev_t e;
            e.cyc = i + 1; e.addr = rd_tbl[i]; e.col = i % 4; e.row = i / 4;
            q_rd_b.push_back(e);
            e.cyc = i + 2; e.addr = i; e.col = 0; e.row = 0;
            q_wr_b.push_back(e);
        end
        q_done_b.push_back(10);
        @(posedge clk); #1;
        base_b  = ncyc;
        start_b = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(posedge clk); #1;
            start_b = 1'b0;
        end
        check("b_rd_left", q_rd_b.size() == 0, $sformatf("%0d pending", q_rd_b.size()), "0 pending");
        check("b_wr_left", q_wr_b.size() == 0, $sformatf("%0d pending", q_wr_b.size()), "0 pending");
        check("b_done_left", q_done_b.size() == 0, $sformatf("%0d pending", q_done_b.size()), "0 pending");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
